// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STAT bit positions and the 2-bit state encoding used by both serial FSMs.
package mmio_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uartState_t;

   localparam logic [31:0] OFF_TXD  = 32'h0;
   localparam logic [31:0] OFF_RXD  = 32'h4;
   localparam logic [31:0] OFF_STAT = 32'h8;

   localparam int STAT_TX_BUSY      = 0;
   localparam int STAT_RX_VALID     = 1;
   localparam int STAT_RX_OVERRUN   = 2;
   localparam int STAT_RX_FRAME_ERR = 3;

endpackage

// File: rtl/mmio_uart_rx.sv
// Receive half of the UART: two-flop synchroniser feeding a mid-bit sampling
// FSM that emits the assembled byte plus one-cycle done / frame-error pulses.
module uart_rx_core
   import mmio_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxLine,
   output logic [7:0] rxByte,
   output logic       rxDone,
   output logic       rxFrameErr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic          syncMeta, rxSync;
   uartState_t    state, stateN;
   logic [CW-1:0] cnt, cntN;
   logic [2:0]    bitIdx, bitIdxN;
   logic [7:0]    shiftReg, shiftN;
   logic          waitHigh, waitHighN;
   logic          doneN, frameErrN;

   // The counter is cleared on the edge that first sees the start bit, so it
   // lags the bit position by one; the compare values absorb that offset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncMeta   <= 1'b1;
         rxSync     <= 1'b1;
         state      <= ST_IDLE;
         cnt        <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         waitHigh   <= 1'b0;
         rxDone     <= 1'b0;
         rxFrameErr <= 1'b0;
      end else begin
         syncMeta   <= rxLine;
         rxSync     <= syncMeta;
         state      <= stateN;
         cnt        <= cntN;
         bitIdx     <= bitIdxN;
         shiftReg   <= shiftN;
         waitHigh   <= waitHighN;
         rxDone     <= doneN;
         rxFrameErr <= frameErrN;
      end
   end

   // After a bad stop bit the line may still be low, so a new start is only
   // accepted once it has been seen high again.
   always_comb begin
      stateN    = state;
      cntN      = cnt;
      bitIdxN   = bitIdx;
      shiftN    = shiftReg;
      waitHighN = waitHigh;
      doneN     = 1'b0;
      frameErrN = 1'b0;
      case (state)
         ST_IDLE: begin
            if (waitHigh) begin
               if (rxSync) waitHighN = 1'b0;
            end else if (!rxSync) begin
               stateN = ST_START;
               cntN   = '0;
            end
         end
         ST_START: begin
            if (cnt == HALF_M1) begin
               cntN    = '0;
               bitIdxN = '0;
               stateN  = rxSync ? ST_IDLE : ST_DATA;
            end else begin
               cntN = cnt + ONE;
            end
         end
         ST_DATA: begin
            if (cnt == LAST) begin
               cntN   = '0;
               shiftN = {rxSync, shiftReg[7:1]};
               if (bitIdx == 3'd7) stateN = ST_STOP;
               else bitIdxN = bitIdx + 3'd1;
            end else begin
               cntN = cnt + ONE;
            end
         end
         ST_STOP: begin
            if (cnt == LAST) begin
               cntN   = '0;
               stateN = ST_IDLE;
               if (rxSync) begin
                  doneN = 1'b1;
               end else begin
                  frameErrN = 1'b1;
                  waitHighN = 1'b1;
               end
            end else begin
               cntN = cnt + ONE;
            end
         end
         default: stateN = ST_IDLE;
      endcase
   end

   assign rxByte = shiftReg;

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped UART on the MEM-stage bus: decodes its own 3-word window,
// runs the transmit FSM and keeps the receive byte and status flags.
module mmio_uart
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h40000020,
   parameter int          CLKS_PER_BIT = 10417
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [31:0] byteOff;
   logic        selTxd, selRxd, selStat;
   logic        txdWrite, statWrite, rxdRead;
   logic        unusedBits;

   // Address[1:0] never takes part in the match.
   assign byteOff   = Address - BASE_ADDR;
   assign selTxd    = {byteOff[31:2], 2'b00} == OFF_TXD;
   assign selRxd    = {byteOff[31:2], 2'b00} == OFF_RXD;
   assign selStat   = {byteOff[31:2], 2'b00} == OFF_STAT;
   assign txdWrite  = MemWrite && selTxd;
   assign statWrite = MemWrite && selStat;
   assign rxdRead   = MemRead && selRxd;
   assign unusedBits = ^{byteOff[1:0], WriteData[31:8]};

   uartState_t    txState, txStateN;
   logic [CW-1:0] txCnt, txCntN;
   logic [2:0]    txIdx, txIdxN;
   logic [7:0]    txData, txDataN;
   logic          txLineN;
   logic          txBusy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         txState <= ST_IDLE;
         txCnt   <= '0;
         txIdx   <= '0;
         txData  <= '0;
         uart_tx <= 1'b1;
      end else begin
         txState <= txStateN;
         txCnt   <= txCntN;
         txIdx   <= txIdxN;
         txData  <= txDataN;
         uart_tx <= txLineN;
      end
   end

   // The line level is computed for the next state and registered, so the
   // current data bit always sits in txData[0] and shifts out at bit end.
   always_comb begin
      txStateN = txState;
      txCntN   = txCnt;
      txIdxN   = txIdx;
      txDataN  = txData;
      txLineN  = 1'b1;
      case (txState)
         ST_IDLE: begin
            if (txdWrite) begin
               txStateN = ST_START;
               txDataN  = WriteData[7:0];
               txCntN   = '0;
               txLineN  = 1'b0;
            end
         end
         ST_START: begin
            txLineN = 1'b0;
            if (txCnt == LAST) begin
               txStateN = ST_DATA;
               txCntN   = '0;
               txIdxN   = '0;
               txLineN  = txData[0];
            end else begin
               txCntN = txCnt + ONE;
            end
         end
         ST_DATA: begin
            txLineN = txData[0];
            if (txCnt == LAST) begin
               txCntN = '0;
               if (txIdx == 3'd7) begin
                  txStateN = ST_STOP;
                  txLineN  = 1'b1;
               end else begin
                  txIdxN  = txIdx + 3'd1;
                  txDataN = {1'b0, txData[7:1]};
                  txLineN = txData[1];
               end
            end else begin
               txCntN = txCnt + ONE;
            end
         end
         ST_STOP: begin
            if (txCnt == LAST) begin
               txStateN = ST_IDLE;
               txCntN   = '0;
            end else begin
               txCntN = txCnt + ONE;
            end
         end
         default: txStateN = ST_IDLE;
      endcase
   end

   assign txBusy = (txState != ST_IDLE);

   logic [7:0] coreByte;
   logic       coreDone, coreFrameErr;

   uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxCore (
      .clk        (clk),
      .reset      (reset),
      .rxLine     (uart_rx),
      .rxByte     (coreByte),
      .rxDone     (coreDone),
      .rxFrameErr (coreFrameErr)
   );

   logic [7:0] rxByteReg;
   logic       rxValid, rxOverrun, rxFrameErrFlag;
   logic       overrunSet;

   // A read of RXD on the completion edge frees the slot, so the new byte loads.
   assign overrunSet = coreDone && rxValid && !rxdRead;

   // Flag sets take priority over software clears on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxByteReg      <= '0;
         rxValid        <= 1'b0;
         rxOverrun      <= 1'b0;
         rxFrameErrFlag <= 1'b0;
      end else begin
         if (coreDone && !overrunSet) begin
            rxByteReg <= coreByte;
            rxValid   <= 1'b1;
         end else if (rxdRead) begin
            rxValid <= 1'b0;
         end
         if (overrunSet) rxOverrun <= 1'b1;
         else if (statWrite && WriteData[STAT_RX_OVERRUN]) rxOverrun <= 1'b0;
         if (coreFrameErr) rxFrameErrFlag <= 1'b1;
         else if (statWrite && WriteData[STAT_RX_FRAME_ERR]) rxFrameErrFlag <= 1'b0;
      end
   end

   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         if (selRxd) begin
            ReadData = {24'b0, rxByteReg};
         end else if (selStat) begin
            ReadData[STAT_TX_BUSY]      = txBusy;
            ReadData[STAT_RX_VALID]     = rxValid;
            ReadData[STAT_RX_OVERRUN]   = rxOverrun;
            ReadData[STAT_RX_FRAME_ERR] = rxFrameErrFlag;
         end
      end
   end

   assign irq = rxValid;

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart with a 4-clock bit period.
module tb_mmio_uart;

   localparam int          CPB  = 4;
   localparam logic [31:0] BASE = 32'h40000020;
   localparam logic [31:0] TXD  = BASE;
   localparam logic [31:0] RXD  = BASE + 32'd4;
   localparam logic [31:0] STAT = BASE + 32'd8;

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        uart_rx;
   logic        uart_tx;
   logic        irq;

   int checks = 0;
   int errors = 0;

   mmio_uart #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .uart_rx   (uart_rx),
      .uart_tx   (uart_tx),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational read with the strobe dropped before the next rising edge.
   task automatic peek(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      Address = addr;
      MemRead = 1'b1;
      #1 data = ReadData;
      #1 MemRead = 1'b0;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      @(negedge clk);
      MemWrite  = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      Address = addr;
      MemRead = 1'b1;
      #1 data = ReadData;
      @(negedge clk);
      MemRead = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      logic [9:0] fr;
      fr = {stopBit, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", uart_tx); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
      peek(STAT, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_stat: got %h expected 00000000", d); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_tx();
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      Address = TXD; WriteData = 32'hA5; MemWrite = 1'b1;
      @(negedge clk);
      MemWrite = 1'b0; Address = STAT; MemRead = 1'b1;
      #1;
      checks++;
      if (ReadData !== 32'h1) begin errors++; $display("[TB] FAIL tx_busy_set: got %h expected 00000001", ReadData); end
      MemRead = 1'b0;
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (uart_tx !== frame[i/4]) begin errors++; $display("[TB] FAIL tx_bit cycle %0d: got %b expected %b", i, uart_tx, frame[i/4]); end
         if (i == 39) begin
            Address = STAT; MemRead = 1'b1; #1;
            checks++;
            if (ReadData !== 32'h1) begin errors++; $display("[TB] FAIL tx_busy_last: got %h expected 00000001", ReadData); end
            MemRead = 1'b0;
         end
         @(negedge clk);
      end
      Address = STAT; MemRead = 1'b1; #1;
      checks++;
      if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL tx_busy_clear: got %h expected 00000000", ReadData); end
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL tx_idle: got %b expected 1", uart_tx); end
      MemRead = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] frame;
      logic       expBit;
      frame = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      Address = TXD; WriteData = 32'hA5; MemWrite = 1'b1;
      @(negedge clk);
      MemWrite = 1'b0;
      for (int i = 0; i < 60; i++) begin
         expBit = (i < 40) ? frame[i/4] : 1'b1;
         checks++;
         if (uart_tx !== expBit) begin errors++; $display("[TB] FAIL b2b_bit cycle %0d: got %b expected %b", i, uart_tx, expBit); end
         if (i == 10) begin
            Address = TXD; WriteData = 32'h11; MemWrite = 1'b1;
         end else begin
            MemWrite = 1'b0;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rx();
      logic [31:0] d;
      sendFrame(8'h3C, 1'b1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL rx_irq_set: got %b expected 1", irq); end
      peek(STAT, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("[TB] FAIL rx_stat_valid: got %h expected 00000002", d); end
      peek(RXD + 32'd3, d);
      checks++;
      if (d !== 32'h3C) begin errors++; $display("[TB] FAIL rx_low_bits_ignored: got %h expected 0000003c", d); end
      peek(BASE + 32'd12, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL rx_past_window: got %h expected 00000000", d); end
      peek(BASE - 32'd4, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL rx_before_window: got %h expected 00000000", d); end
      peek(TXD, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL rx_txd_reads_zero: got %h expected 00000000", d); end
      @(negedge clk);
      Address = RXD; MemRead = 1'b0; #1;
      checks++;
      if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL rx_no_strobe: got %h expected 00000000", ReadData); end
      busRead(RXD, d);
      checks++;
      if (d !== 32'h3C) begin errors++; $display("[TB] FAIL rx_data: got %h expected 0000003c", d); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rx_irq_clear: got %b expected 0", irq); end
      peek(STAT, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL rx_stat_clear: got %h expected 00000000", d); end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      sendFrame(8'h01, 1'b1);
      sendFrame(8'h02, 1'b1);
      peek(STAT, d);
      checks++;
      if (d !== 32'h6) begin errors++; $display("[TB] FAIL ovr_stat: got %h expected 00000006", d); end
      peek(RXD, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("[TB] FAIL ovr_data_kept: got %h expected 00000001", d); end
      busWrite(STAT, 32'h4);
      peek(STAT, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("[TB] FAIL ovr_clear: got %h expected 00000002", d); end
      busRead(RXD, d);
   endtask

   task automatic test_frame_err();
      logic [31:0] d;
      sendFrame(8'hFF, 1'b0);
      peek(STAT, d);
      checks++;
      if (d !== 32'h8) begin errors++; $display("[TB] FAIL ferr_stat: got %h expected 00000008", d); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ferr_irq: got %b expected 0", irq); end
      busWrite(STAT, 32'h8);
      peek(STAT, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL ferr_clear: got %h expected 00000000", d); end
      @(negedge clk);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      peek(STAT, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_stat: got %h expected 00000000", d); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL glitch_irq: got %b expected 0", irq); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      sendFrame(8'h77, 1'b1);
      busWrite(TXD, 32'h00);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (8) @(negedge clk);
      peek(STAT, d);
      checks++;
      if (d !== 32'h3) begin errors++; $display("[TB] FAIL pre_reset_stat: got %h expected 00000003", d); end
      checks++;
      if (uart_tx !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_tx: got %b expected 0", uart_tx); end
      @(negedge clk);
      reset = 1'b0;
      uart_rx = 1'b1;
      Address = STAT; MemRead = 1'b1;
      #1;
      checks++;
      if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_tx: got %b expected 1", uart_tx); end
      checks++;
      if (ReadData !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_stat: got %h expected 00000000", ReadData); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_irq: got %b expected 0", irq); end
      MemRead = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      sendFrame(8'h5A, 1'b1);
      busRead(RXD, d);
      checks++;
      if (d !== 32'h5A) begin errors++; $display("[TB] FAIL post_reset_rx: got %h expected 0000005a", d); end
      peek(STAT, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_stat: got %h expected 00000000", d); end
   endtask

   initial begin
      reset     = 1'b0;
      Address   = '0;
      WriteData = '0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      uart_rx   = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_tx();
      test_back_to_back();
      test_rx();
      test_overrun();
      test_frame_err();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped UART responder on the pipeline's MEM-stage data bus, alongside the LED/7-seg peripherals in data memory.
- The CPU acts as bus initiator with loads and stores. This block answers those accesses and implements both ends of the serial link:
  - a transmitter that serialises a byte written by the CPU;
  - a receiver that deserialises incoming bytes for the CPU to read.
- The parent decodes nothing. The block matches its own address window.

Parameters:
BASE_ADDR, 32'h40000020, byte address of the first register (word-aligned; window is 3 words)
CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 4

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
Address  in  32  byte address from MEM-stage ALU result
WriteData  in  32  store data
MemRead  in  1  load strobe
MemWrite  in  1  store strobe
ReadData  out  32  load data; 0 when address not in window or MemRead=0
uart_rx  in  1  serial input, asynchronous to clk
uart_tx  out  1  serial output, idle high
irq  out  1  high while a received byte is unread (= rx_valid)

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 TXD: write bits[7:0] starts transmission; reads 0.
  - +4 RXD: reads {24'b0, rx_byte}.
  - +8 STAT: bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, bit3 rx_frame_err; other bits read 0.
  - Writing STAT with bit2/bit3 = 1 clears the corresponding flag.
- Address[1:0] is ignored. Any other address in the window is a no-op and reads 0.
- Reads are combinational (same cycle as MemRead, like data memory).
- Side effect: a clock edge with MemRead=1 and the RXD address clears rx_valid.
- Reset (reset=0, async):
  - uart_tx=1, tx FSM IDLE, rx FSM IDLE;
  - rx_byte=0; all flags 0; irq=0; synchroniser flops=1.
  - A reset mid-frame aborts immediately. The line goes high the cycle reset asserts.
- TX FSM states: IDLE, START, DATA, STOP.
  - A TXD write in IDLE latches the byte and enters START on the next edge. tx_busy=1 from that edge on.
  - START drives 0 for CLKS_PER_BIT cycles.
  - DATA drives bits LSB-first, 8 x CLKS_PER_BIT.
  - STOP drives 1 for CLKS_PER_BIT, then returns to IDLE and tx_busy=0.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - A TXD write while tx_busy=1 is silently dropped. There is no stall and no error flag.
  - uart_tx is registered (glitch-free).
- RX path: uart_rx passes through a 2-flop synchroniser before the FSM.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised 0 enters START and resets the bit counter.
  - START: at count CLKS_PER_BIT/2, if the line is 1, it was a glitch and the FSM returns to IDLE. Otherwise it enters DATA.
  - DATA: samples at each subsequent CLKS_PER_BIT interval (mid-bit), LSB-first, 8 bits.
  - STOP: samples once at mid-bit, then the FSM returns to IDLE.
- STOP outcomes:
  - Stop bit = 1 and rx_valid = 0: load rx_byte, set rx_valid.
  - Stop bit = 1 and rx_valid = 1: byte dropped, rx_overrun set, rx_byte unchanged.
  - Stop bit = 0: byte dropped, rx_frame_err set. The FSM waits in IDLE for the line to return high before accepting a new start.
- Simultaneous events:
  - RXD read and new-byte completion on the same edge: the load wins. rx_byte takes the new value, rx_valid stays 1, no overrun.
  - STAT clear and a flag-set on the same edge: set wins.
- Counters: bit-period counter sized clog2(CLKS_PER_BIT); bit index 3 bits. No wrap beyond the 8 data bits.

Decomposition:
- Shared package:
  - register offsets (TXD/RXD/STAT);
  - STAT bit positions;
  - FSM state encodings (2-bit, shared by TX and RX).
- One natural sub-module: uart_rx_core (synchroniser + RX FSM; outputs byte and done/frame_err pulses). The TX FSM and register file stay in the top.

Test Plan:
1. CLKS_PER_BIT=4: reset released, write TXD=8'hA5 -> next edge tx_busy=1; uart_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy=0 after 40 cycles.
2. Write TXD=8'h11 during a transmission of 8'hA5 -> serial stream still carries A5 only; no second frame follows.
3. Drive uart_rx with frame for 8'h3C -> rx_valid=1, irq=1, RXD reads 32'h0000003C; the read edge clears rx_valid and irq.
4. Receive 8'h01, then 8'h02 without reading -> RXD=8'h01, STAT=32'h6; writing STAT=4 clears it to 32'h2.
5. Frame for 8'hFF with stop bit 0 -> rx_valid stays 0 and STAT bit3=1. A 1-cycle low glitch on uart_rx -> no frame, no flags.
6. Assert reset mid-TX and mid-RX -> uart_tx=1 the same cycle, STAT=0, ReadData=0. The next valid frame is received correctly.
